// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed 8-digit 7-segment scanner with per-digit hex/dp registers and anti-ghost blanking.
// Latency: seg/en/frame_done are registered, one cycle behind the scan state; digit writes are forwarded to seg in that same cycle.
// Backpressure: none; run=0 freezes the scan in place and blanks the display.
module seg_scan_ctrl #(
    parameter int DWELL = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic [7:0] digit_mask,
    output logic [7:0] seg,
    output logic [7:0] en,
    output logic       frame_done
);

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             wrap_pend_q, wrap_pend_d;

    logic [3:0]       digit_val [8];
    logic             digit_dp  [8];

    logic [3:0]       shown_val;
    logic             shown_dp;
    logic [7:0]       seg_d, en_d;
    logic             frame_done_d;

    // Active-low a..g in bits 7..1, dp (bit 0) left dark.
    function automatic logic [7:0] hex_code(input logic [3:0] v);
        logic [7:0] c;
        case (v)
            4'h0:    c = 8'h03;
            4'h1:    c = 8'h9F;
            4'h2:    c = 8'h25;
            4'h3:    c = 8'h0D;
            4'h4:    c = 8'h99;
            4'h5:    c = 8'h49;
            4'h6:    c = 8'h41;
            4'h7:    c = 8'h1F;
            4'h8:    c = 8'h01;
            4'h9:    c = 8'h19;
            4'hA:    c = 8'h11;
            4'hB:    c = 8'hC1;
            4'hC:    c = 8'h63;
            4'hD:    c = 8'h85;
            4'hE:    c = 8'h61;
            default: c = 8'h71;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                digit_val[i] <= 4'h0;
                digit_dp[i]  <= 1'b0;
            end
        end else if (wr_en) begin
            digit_val[wr_addr] <= wr_data;
            digit_dp[wr_addr]  <= wr_dp;
        end
    end

    // Forward a same-cycle write to the shown digit so it reaches seg without an extra cycle.
    always_comb begin
        shown_val = digit_val[idx_q];
        shown_dp  = digit_dp[idx_q];
        if (wr_en && (wr_addr == idx_q)) begin
            shown_val = wr_data;
            shown_dp  = wr_dp;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wrap_pend_d = wrap_pend_q;
        if (run) begin
            wrap_pend_d = 1'b0;
            if (state_q == SHOW) begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == BLANK_LAST) begin
                    state_d     = SHOW;
                    cnt_d       = '0;
                    idx_d       = idx_q + 3'd1;
                    // frame_done is issued one cycle later so it lines up with en returning to digit 0.
                    wrap_pend_d = (idx_q == 3'd7);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        seg_d        = 8'hFF;
        en_d         = 8'hFF;
        frame_done_d = run & wrap_pend_q;
        if (run && (state_q == SHOW) && digit_mask[idx_q]) begin
            en_d  = ~(8'h01 << idx_q);
            seg_d = hex_code(shown_val) & ~{7'b0, shown_dp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SHOW;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            wrap_pend_q <= 1'b0;
            seg         <= 8'hFF;
            en          <= 8'hFF;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wrap_pend_q <= wrap_pend_d;
            seg         <= seg_d;
            en          <= en_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DWELL=4, BLANK=2 (6-cycle slots, 48-cycle frames).
module tb_seg_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 8 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic [7:0] digit_mask;
    logic [7:0] seg;
    logic [7:0] en;
    logic       frame_done;

    int n_vec = 0;
    int n_err = 0;
    int q = 0;
    int last_fd_q = 0;

    logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    logic [3:0] mv [8];
    logic       md [8];

    seg_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .digit_mask (digit_mask),
        .seg        (seg),
        .en         (en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (q=%0d)", tag, got, exp, q);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (q=%0d)", tag, got, exp, q);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (run && !rst) q++;
    endtask

    // q counts run-active edges since reset release; outputs after edge q reflect frame position q-1.
    task automatic check_model(input string tag);
        int p;
        int s;
        logic [7:0] e_en;
        logic [7:0] e_seg;
        logic       e_fd;
        e_en  = 8'hFF;
        e_seg = 8'hFF;
        e_fd  = 1'b0;
        if (run) begin
            p = (q - 1) % FRAME;
            s = p / SLOT;
            if (((p % SLOT) < DWELL) && digit_mask[s]) begin
                e_en  = ~(8'h01 << s);
                e_seg = hex_tab[mv[s]] & ~{7'b0, md[s]};
            end
            e_fd = (p == 0) && (q > 1);
        end
        chk8({tag, "_en"}, en, e_en);
        chk8({tag, "_seg"}, seg, e_seg);
        chk1({tag, "_fd"}, frame_done, e_fd);
        if (frame_done === 1'b1) begin
            if (last_fd_q > 0) begin
                n_vec++;
                assert (q - last_fd_q == FRAME) else begin
                    n_err++;
                    $error("FAIL %s_period: observed %0d expected %0d", tag, q - last_fd_q, FRAME);
                end
            end
            last_fd_q = q;
        end
    endtask

    task automatic run_model(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check_model(tag);
        end
    endtask

    task automatic advance_to(input string tag, input int pos);
        for (int k = 0; k < FRAME + 2 && (((q - 1) % FRAME) != pos); k++) begin
            tick();
            check_model(tag);
        end
    endtask

    initial begin
        rst        = 1'b1;
        run        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 4'h0;
        wr_dp      = 1'b0;
        digit_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            mv[i] = 4'h0;
            md[i] = 1'b0;
        end

        // Reset, with a write presented during reset that must be ignored.
        tick();
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 4'h9;
        wr_dp   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk8("reset_en", en, 8'hFF);
        chk8("reset_seg", seg, 8'hFF);
        chk1("reset_fd", frame_done, 1'b0);

        // Release: digit 0 for DWELL, blank for BLANK, then digit 1 (still 0 despite reset-time write).
        rst = 1'b0;
        for (int i = 0; i < DWELL; i++) begin
            tick();
            chk8("rel_show0_en", en, 8'hFE);
            chk8("rel_show0_seg", seg, 8'h03);
        end
        for (int i = 0; i < BLANK; i++) begin
            tick();
            chk8("rel_gap_en", en, 8'hFF);
            chk8("rel_gap_seg", seg, 8'hFF);
        end
        tick();
        chk8("rel_show1_en", en, 8'hFD);
        chk8("rel_show1_seg", seg, 8'h03);

        // Digit 3 = 5 with dp lit, then scan two full frames.
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 4'h5;
        wr_dp   = 1'b1;
        mv[3]   = 4'h5;
        md[3]   = 1'b1;
        tick();
        wr_en = 1'b0;
        check_model("wr3");
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            check_model("scan");
            if (((q - 1) % FRAME) == 3 * SLOT) begin
                chk8("slot3_en", en, 8'hF7);
                chk8("slot3_seg", seg, 8'h48);
            end
        end

        // Only digit 0 enabled; the others stay dark but keep their slot time.
        digit_mask = 8'hFE;
        run_model("mask", FRAME + 4);
        digit_mask = 8'hFF;

        // Freeze mid-slot 2 for 10 cycles, then resume.
        advance_to("pre_pause", 2 * SLOT + 1);
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk8("pause_en", en, 8'hFF);
            chk8("pause_seg", seg, 8'hFF);
            chk1("pause_fd", frame_done, 1'b0);
        end
        run = 1'b1;
        tick();
        chk8("resume_en", en, 8'hFB);
        check_model("resume");
        run_model("post_pause", SLOT + 2);

        // Overwrite digit 0 while it is on the display.
        advance_to("pre_fwd", 1);
        chk8("pre_fwd_seg", seg, 8'h03);
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 4'hA;
        wr_dp   = 1'b0;
        mv[0]   = 4'hA;
        md[0]   = 1'b0;
        tick();
        wr_en = 1'b0;
        chk8("wr_fwd_seg", seg, 8'h11);
        chk8("wr_fwd_en", en, 8'hFE);
        check_model("wr_fwd");

        // Reset in the middle of slot 5: blank, then restart at digit 0 with cleared registers.
        advance_to("pre_rst", 5 * SLOT + 1);
        chk8("pre_rst_en", en, 8'hDF);
        rst = 1'b1;
        tick();
        chk8("midrst_en", en, 8'hFF);
        chk8("midrst_seg", seg, 8'hFF);
        chk1("midrst_fd", frame_done, 1'b0);
        rst       = 1'b0;
        q         = 0;
        last_fd_q = 0;
        for (int i = 0; i < 8; i++) begin
            mv[i] = 4'h0;
            md[i] = 1'b0;
        end
        for (int i = 0; i < DWELL; i++) begin
            tick();
            chk8("restart_en", en, 8'hFE);
            chk8("restart_seg", seg, 8'h03);
        end
        run_model("restart", 2 * SLOT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
